// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared constants for the fixed-point squarer: decimal scaling, saturation
// limits, operand/result widths, FSM state encoding, iteration counts and the
// fixed start-to-done latency. Also provides to_fixed(), which builds the
// scaled operand whole*100 + frac from shifts and adds only.
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam int FRAC_SCALE = 100;
    localparam int MAX_FRAC   = 99;
    localparam int MAX_INT    = 511;

    localparam int WHOLE_W    = 7;   // integer part of operand
    localparam int FRAC_W     = 7;   // hundredths (operand and result)
    localparam int OPND_W     = 14;  // whole*100 + frac, max 12799
    localparam int PROD_W     = 28;  // square of the scaled operand
    localparam int INT_W      = 9;   // integer part of result
    localparam int CNT_W      = 5;   // iteration counter

    localparam int MULT_ITERS = 14;
    localparam int DIV_ITERS  = 28;
    localparam int SQ_LATENCY = 71;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MULT = 3'd1;
    localparam logic [2:0] ST_DIV1 = 3'd2;
    localparam logic [2:0] ST_DIV2 = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // whole*100 = whole*64 + whole*32 + whole*4
    function automatic logic [OPND_W-1:0] to_fixed(input logic [WHOLE_W-1:0] whole,
                                                   input logic [FRAC_W-1:0]  frac);
        logic [OPND_W-1:0] w;
        w = {{(OPND_W-WHOLE_W){1'b0}}, whole};
        return (w << 6) + (w << 5) + (w << 2) + {{(OPND_W-FRAC_W){1'b0}}, frac};
    endfunction

endpackage

// File: rtl/div100_seq.sv
// -----------------------------------------------------------------------------
// div100_seq
// Sequential restoring divider by the constant 100, one quotient bit per cycle,
// 28 steps per division.
//   clk, rst   : clock, synchronous active-high reset
//   load       : start a division; the first step is taken from dividend on
//                the same edge, the remaining 27 follow on their own
//   dividend   : 28-bit value to divide, sampled only while load is high
//   quotient   : 28-bit quotient, valid once 28 steps are complete
//   remainder  : 7-bit remainder (0..99), valid with quotient
// Once complete the result holds until the next load.
// -----------------------------------------------------------------------------
module div100_seq
    import calc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [PROD_W-1:0] dividend,
    output logic [PROD_W-1:0] quotient,
    output logic [6:0]        remainder
);

    logic [PROD_W-1:0] r_quot;   // shifts dividend out, quotient bits in
    logic [6:0]        r_rem;
    logic [CNT_W-1:0]  r_steps;  // steps taken since load; 0 or 28 = idle

    logic [PROD_W-1:0] w_src_q;
    logic [6:0]        w_src_r;
    logic [7:0]        w_trial;
    logic              w_fits;
    logic              w_run;

    assign w_run = load || ((r_steps != '0) && (r_steps != CNT_W'(DIV_ITERS)));

    always_comb begin
        w_src_q = load ? dividend : r_quot;
        w_src_r = load ? 7'd0 : r_rem;
        // Partial remainder is < 100, so 2*rem+1 < 200 fits in 8 bits.
        w_trial = {w_src_r, w_src_q[PROD_W-1]};
        w_fits  = (w_trial >= 8'(FRAC_SCALE));
    end

    // NOTE: sequential state uses <= so every register samples the values from
    // before the edge; blocking = here would let later lines see updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quot  <= '0;
            r_rem   <= '0;
            r_steps <= '0;
        end else if (w_run) begin
            r_quot  <= {w_src_q[PROD_W-2:0], w_fits};
            r_rem   <= w_fits ? 7'(w_trial - 8'(FRAC_SCALE)) : w_trial[6:0];
            r_steps <= load ? CNT_W'(1) : r_steps + CNT_W'(1);
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;

endmodule

// File: rtl/fixed_squarer.sv
// -----------------------------------------------------------------------------
// fixed_squarer
// Squares a decimal fixed-point operand whole.frac (frac in hundredths) and
// returns the truncated square as integer part plus hundredths, saturating at
// 511.99. Fixed latency: done is high in the 71st cycle after start is
// accepted (1st cycle for an operand with frac > 99).
//   clk, rst      : clock, synchronous active-high reset
//   start         : request, sampled only in IDLE
//   whole_in      : integer part of operand, 0..127
//   fracture_in   : hundredths of operand, 0..99 legal
//   busy          : high in MULT, DIV1, DIV2
//   done          : one-cycle pulse in DONE, results valid
//   number_out    : integer part of the square (saturated to 511)
//   fracture_out  : hundredths of the square (99 when saturated)
//   overflow      : integer part of the square exceeded 511
//   invalid       : fracture_in exceeded 99
// Datapath: x = whole*100+frac, p = x*x by 14 shift-add steps, then p/100 and
// (p/100)/100 through one shared divider, giving floor(p/10000) and
// floor(p/100) mod 100.
// -----------------------------------------------------------------------------
module fixed_squarer
    import calc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WHOLE_W-1:0] whole_in,
    input  logic [FRAC_W-1:0]  fracture_in,
    output logic               busy,
    output logic               done,
    output logic [INT_W-1:0]   number_out,
    output logic [FRAC_W-1:0]  fracture_out,
    output logic               overflow,
    output logic               invalid
);

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;      // cycles spent in the current state
    logic [PROD_W-1:0] r_mcand;    // multiplicand, shifted left each step
    logic [OPND_W-1:0] r_mplier;   // multiplier, shifted right each step
    logic [PROD_W-1:0] r_prod;     // running product
    logic [INT_W-1:0]  r_number;
    logic [FRAC_W-1:0] r_frac;
    logic              r_ovf;
    logic              r_inv;

    logic [2:0]        w_state_nxt;
    logic [OPND_W-1:0] w_x;
    logic              w_frac_bad;
    logic              w_accept;
    logic              w_mult_last;
    logic              w_div_last;
    logic              w_div_load;
    logic [PROD_W-1:0] w_div_dividend;
    logic [PROD_W-1:0] w_quot;
    logic [6:0]        w_rem;

    assign w_x         = to_fixed(whole_in, fracture_in);
    assign w_frac_bad  = (fracture_in > FRAC_W'(MAX_FRAC));
    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_mult_last = (r_cnt == CNT_W'(MULT_ITERS - 1));
    assign w_div_last  = (r_cnt == CNT_W'(DIV_ITERS - 1));

    // Each phase takes its first step on the edge that enters it, fed by the
    // previous phase's finished register: the accept edge takes multiply step
    // one from the input operand, and the divider is loaded in the last cycle
    // of MULT and of DIV1. The 70 dependent steps therefore complete one edge
    // before DONE, and the results are registered as DONE is entered.
    assign w_div_load     = ((r_state == ST_MULT) && w_mult_last) ||
                            ((r_state == ST_DIV1) && w_div_last);
    assign w_div_dividend = (r_state == ST_MULT) ? r_prod : w_quot;

    div100_seq u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (w_div_load),
        .dividend  (w_div_dividend),
        .quotient  (w_quot),
        .remainder (w_rem)
    );

    // NOTE: the default assignment first gives w_state_nxt a value on every
    // path, so this stays combinational instead of inferring a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)       w_state_nxt = w_frac_bad ? ST_DONE : ST_MULT;
            ST_MULT: if (w_mult_last) w_state_nxt = ST_DIV1;
            ST_DIV1: if (w_div_last)  w_state_nxt = ST_DIV2;
            ST_DIV2: if (w_div_last)  w_state_nxt = ST_DONE;
            ST_DONE:                  w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_number <= '0;
            r_frac   <= '0;
            r_ovf    <= 1'b0;
            r_inv    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (busy) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Multiply: step one on accept, steps two..fourteen in MULT.
            if (w_accept && !w_frac_bad) begin
                r_mplier <= w_x >> 1;
                r_mcand  <= {{(PROD_W-OPND_W-1){1'b0}}, w_x, 1'b0};
                r_prod   <= w_x[0] ? {{(PROD_W-OPND_W){1'b0}}, w_x} : '0;
            end else if ((r_state == ST_MULT) && !w_mult_last) begin
                if (r_mplier[0]) begin
                    r_prod <= r_prod + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end

            // Results change only on the edge entering DONE.
            if (w_accept && w_frac_bad) begin
                r_number <= '0;
                r_frac   <= '0;
                r_ovf    <= 1'b0;
                r_inv    <= 1'b1;
            end else if ((r_state == ST_DIV2) && w_div_last) begin
                if (w_quot > PROD_W'(MAX_INT)) begin
                    r_number <= INT_W'(MAX_INT);
                    r_frac   <= FRAC_W'(MAX_FRAC);
                    r_ovf    <= 1'b1;
                end else begin
                    r_number <= w_quot[INT_W-1:0];
                    r_frac   <= w_rem;
                    r_ovf    <= 1'b0;
                end
                r_inv <= 1'b0;
            end
        end
    end

    assign busy         = (r_state == ST_MULT) || (r_state == ST_DIV1) ||
                          (r_state == ST_DIV2);
    assign done         = (r_state == ST_DONE);
    assign number_out   = r_number;
    assign fracture_out = r_frac;
    assign overflow     = r_ovf;
    assign invalid      = r_inv;

endmodule

// File: doc/fixed_squarer.md
FIXED_SQUARER -- requirements
Module: fixed_squarer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- whole_in  in  7  integer part of operand, 0..127.
- fracture_in  in  7  hundredths of operand, 0..99 legal.
- busy  out  1  high from the cycle after start is accepted until the cycle before done.
- done  out  1  one-cycle pulse; results valid.
- number_out  out  9  integer part of the square, 0..511.
- fracture_out  out  7  hundredths of the square, 0..99.
- overflow  out  1  square integer part exceeded 511.
- invalid  out  1  fracture_in exceeded 99.

Function
REQ-003 SHALL compute, for the latched operand x = whole_in*100 + fracture_in (14 bits), the 28-bit product p = x*x.
REQ-004 SHALL set number_out = floor(p/10000) and fracture_out = floor(p/100) mod 100, truncating with no rounding.
REQ-005 SHALL use the states IDLE, MULT, DIV1, DIV2 and DONE, with a 5-bit iteration counter.
REQ-006 IDLE with start=1: SHALL latch the operands, compute x and go to MULT; if fracture_in>99, SHALL go directly to DONE.
REQ-007 MULT SHALL perform exactly 14 shift-add iterations, then go to DIV1.
REQ-008 DIV1 SHALL perform 28 restoring iterations of p/100, giving m, then go to DIV2.
REQ-009 DIV2 SHALL perform 28 restoring iterations of m/100, giving quotient q and remainder r, then go to DONE.
REQ-010 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-011 Latency SHALL be fixed: done is asserted exactly 71 cycles after the start-accept edge for a valid operand, and exactly 1 cycle after it for an invalid operand.
REQ-012 start asserted outside IDLE SHALL be ignored; a start held high in IDLE starts a new operation on the cycle after DONE.
REQ-013 If q>511: number_out=511, fracture_out=99, overflow=1; otherwise number_out=q, fracture_out=r, overflow=0.
REQ-014 Invalid operand: number_out=0, fracture_out=0, overflow=0, invalid=1.
REQ-015 number_out, fracture_out, overflow and invalid SHALL update only in the DONE cycle and hold until the next DONE.
REQ-016 busy SHALL equal (state is MULT, DIV1 or DIV2); done SHALL equal (state is DONE).

Reset
REQ-017 rst SHALL force IDLE and zero the counter, all datapath registers and every output (busy, done, number_out, fracture_out, overflow, invalid) on the next edge.
REQ-018 rst asserted mid-operation SHALL abort it with no done pulse; a start in the first cycle after rst deasserts SHALL be accepted.
REQ-019 rst SHALL take priority over start in the same cycle.

Structure
REQ-020 Shared package calc_pkg SHALL hold FRAC_SCALE=100, MAX_FRAC=99, MAX_INT=511, the operand and result widths, the state encoding and the latency constant SQ_LATENCY=71.
REQ-021 The /100 restoring divider SHALL be a single sub-module div100_seq, reused for both DIV1 and DIV2, with ports load, dividend[27:0], quotient[27:0], remainder[6:0] and a fixed 28-cycle duration.
REQ-022 The multiplier SHALL be inline in fixed_squarer; no multiply operator SHALL be inferred.

Verification
REQ-023 whole=18, frac=97 -> done at +71, number_out=359, fracture_out=86, overflow=0.
REQ-024 whole=1, frac=41 -> 1.98; whole=3, frac=0 -> 9.00; whole=0, frac=0 -> 0.00, all with done at +71.
REQ-025 whole=22, frac=63 (true square 512.11) -> number_out=511, fracture_out=99, overflow=1.
REQ-026 frac=100 -> done at +1, invalid=1, outputs 0; a following valid start is accepted normally.
REQ-027 start pulsed again at +10 -> ignored, single done at +71 with the first operand's result.
REQ-028 rst at +30 -> no done, all outputs 0; a new start after reset gives the correct result.
